// File: rtl/hilo_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_fwd_unit
// Description : HI/LO architectural registers with an N-stage forwarding
//               network into issue, plus a mul/div occupancy tracker that
//               requests a stall when HI/LO is read during a long operation.
//               Optional performance counters are enabled by HILO_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_fwd_unit #(
    parameter int DATA_W     = 32,
    parameter int FWD_STAGES = 4,
    parameter int STALL_W    = 6,
    parameter int ISSUE_BIT  = 3,
    parameter int MUL_LAT    = 2,
    parameter int DIV_LAT    = 33
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [STALL_W-1:0]           stall,
    input  logic                         flush,
    input  logic [FWD_STAGES-1:0]        fwd_hi_we,
    input  logic [FWD_STAGES-1:0]        fwd_lo_we,
    input  logic [FWD_STAGES*DATA_W-1:0] fwd_hi_data,
    input  logic [FWD_STAGES*DATA_W-1:0] fwd_lo_data,
    input  logic                         wb_hi_we,
    input  logic                         wb_lo_we,
    input  logic [DATA_W-1:0]            wb_hi_data,
    input  logic [DATA_W-1:0]            wb_lo_data,
    input  logic                         long_start,
    input  logic                         long_is_div,
    input  logic                         rd_hilo,
    output logic [DATA_W-1:0]            hi_o,
    output logic [DATA_W-1:0]            lo_o,
    output logic                         hilo_busy,
    output logic                         stallreq_o
`ifdef HILO_PERF_EN
    ,
    output logic [31:0]                  stall_cycles,
    output logic [31:0]                  long_ops
`endif
);

    localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);
    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_LAT);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(DIV_LAT);

    logic [DATA_W-1:0]  r_hi;
    logic [DATA_W-1:0]  r_lo;
    logic [DATA_W-1:0]  w_hi_fwd;
    logic [DATA_W-1:0]  w_lo_fwd;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_issue_stall;
    logic               w_next_stall;

    assign w_issue_stall = stall[ISSUE_BIT];
    assign w_next_stall  = stall[ISSUE_BIT+1];

    // Architectural commit; HI and LO are written independently.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (wb_hi_we) r_hi <= wb_hi_data;
            if (wb_lo_we) r_lo <= wb_lo_data;
        end
    end

    // Walk from oldest to youngest so the lowest enabled index ends up winning.
    always_comb begin
        w_hi_fwd = wb_hi_we ? wb_hi_data : r_hi;
        w_lo_fwd = wb_lo_we ? wb_lo_data : r_lo;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (fwd_hi_we[k]) w_hi_fwd = fwd_hi_data[k*DATA_W +: DATA_W];
            if (fwd_lo_we[k]) w_lo_fwd = fwd_lo_data[k*DATA_W +: DATA_W];
        end
    end

    // Issue stalled while the next stage advances -> inject a zero bubble.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_o <= '0;
            lo_o <= '0;
        end else if (w_issue_stall && !w_next_stall) begin
            hi_o <= '0;
            lo_o <= '0;
        end else if (!w_issue_stall) begin
            hi_o <= w_hi_fwd;
            lo_o <= w_lo_fwd;
        end
    end

    // Long-op occupancy runs free of the pipeline stall bus.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (long_start) begin
            r_cnt <= long_is_div ? c_DIV_LOAD : c_MUL_LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign hilo_busy  = (r_cnt != '0);
    assign stallreq_o = rd_hilo & hilo_busy;

`ifdef HILO_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_long_ops;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stall_cycles <= '0;
            r_long_ops     <= '0;
        end else begin
            if (stallreq_o && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
            if (long_start && !flush)                 r_long_ops     <= r_long_ops + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign long_ops     = r_long_ops;
`endif

endmodule
`default_nettype wire
